// File: rtl/instr_mem_pkg.sv
// instr_mem_pkg: shared fault codes, load/fetch states and MIPS encoding helpers for the instruction memory
package instr_mem_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2} state_t;
  localparam logic [1:0] FAULT_OK = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_RANGE = 2'b10;
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2b;
  localparam logic [5:0] FN_ADD = 6'h20;
  function automatic logic [31:0] mk_itype(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
endpackage

// File: rtl/byte_word_assembler.sv
// byte_word_assembler: packs a byte stream into 32-bit words, zero-padding a short final word
module byte_word_assembler #(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic        last,
  input  logic [7:0]  byte_in,
  output logic        word_ready,
  output logic [31:0] word
);
  logic [1:0] cnt;
  logic [1:0] lane;
  logic [31:0] acc;
  always_comb begin
    lane = BIG_ENDIAN ? 2'd3 - cnt : cnt;
    word = acc | (32'(byte_in) << {lane, 3'b000});
    word_ready = byte_valid && (last || cnt == 2'd3);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      acc <= '0;
    end else if (clear) begin
      cnt <= '0;
      acc <= '0;
    end else if (byte_valid) begin
      cnt <= word_ready ? 2'd0 : cnt + 2'd1;
      acc <= word_ready ? 32'd0 : word;
    end
endmodule

// File: rtl/instr_mem_loadable.sv
// instr_mem_loadable: run-time loadable instruction memory with a registered, fault-checked fetch port
module instr_mem_loadable import instr_mem_pkg::*; #(
  parameter int DEPTH_WORDS = 64,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_start,
  input  logic        load_byte_valid,
  input  logic [7:0]  load_byte,
  input  logic        load_last,
  output logic        load_done,
  output logic        load_overflow,
  output logic        loading,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        fetch_ready,
  output logic        fetch_valid,
  output logic [31:0] fetch_instr,
  output logic [1:0]  fetch_fault
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = AW + 1;
  state_t state, state_nx;
  logic [PW-1:0] ptr;
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] word;
  logic full, take, word_ready, fetch_acc, last_acc;
  logic [1:0] fault_nx;
  // a restart pulse wins over any byte presented in the same cycle
  always_comb begin
    loading = state == LOAD;
    fetch_ready = !loading;
    fetch_acc = fetch_req && fetch_ready;
    full = ptr == PW'(DEPTH_WORDS);
    take = loading && load_byte_valid && !load_start && !full;
    last_acc = loading && load_byte_valid && load_last && !load_start;
    state_nx = load_start ? LOAD : last_acc ? RUN : state;
    fault_nx = fetch_addr[1:0] != 2'b00 ? FAULT_MISALIGN :
               fetch_addr[31:2] >= 30'(DEPTH_WORDS) ? FAULT_RANGE : FAULT_OK;
  end
  byte_word_assembler #(.BIG_ENDIAN(BIG_ENDIAN)) u_asm (
    .clk(clk),
    .rst_n(rst_n),
    .clear(load_start),
    .byte_valid(take),
    .last(load_last),
    .byte_in(load_byte),
    .word_ready(word_ready),
    .word(word)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      load_done <= 1'b0;
      load_overflow <= 1'b0;
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else begin
      state <= state_nx;
      load_done <= last_acc;
      load_overflow <= load_start ? 1'b0 : load_overflow | (loading && load_byte_valid && full);
      ptr <= load_start ? '0 : ptr + PW'(word_ready);
      if (word_ready) mem[ptr[AW-1:0]] <= word;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fetch_valid <= 1'b0;
      fetch_instr <= '0;
      fetch_fault <= FAULT_OK;
    end else begin
      fetch_valid <= fetch_acc;
      if (fetch_acc) begin
        fetch_fault <= fault_nx;
        fetch_instr <= fault_nx == FAULT_OK ? mem[fetch_addr[AW+1:2]] : 32'd0;
      end
    end
endmodule

// File: tb/tb_instr_mem_loadable.sv
// tb_instr_mem_loadable: scoreboard bench over three configurations (64/BE, 2/BE, 64/LE)
module tb_instr_mem_loadable;
  import instr_mem_pkg::*;
  typedef struct {int d; logic [31:0] i; logic [1:0] f;} exp_t;
  logic clk = 0;
  logic rst_n = 0;
  logic ls[3], bv[3], lst[3], fr[3];
  logic [7:0] lb[3];
  logic [31:0] fa[3];
  logic ld[3], lo[3], lg[3], frdy[3], fv[3];
  logic [31:0] fi[3];
  logic [1:0] ff[3];
  exp_t q[$];
  exp_t mon_e;
  logic [7:0] img[$];
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    instr_mem_loadable #(.DEPTH_WORDS(g == 1 ? 2 : 64), .BIG_ENDIAN(g != 2)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .load_start(ls[g]),
      .load_byte_valid(bv[g]),
      .load_byte(lb[g]),
      .load_last(lst[g]),
      .load_done(ld[g]),
      .load_overflow(lo[g]),
      .loading(lg[g]),
      .fetch_req(fr[g]),
      .fetch_addr(fa[g]),
      .fetch_ready(frdy[g]),
      .fetch_valid(fv[g]),
      .fetch_instr(fi[g]),
      .fetch_fault(ff[g])
    );
  end
  always @(negedge clk)
    for (int g = 0; g < 3; g++)
      if (fv[g] === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL fetch_unexpected dut=%0d instr=%h fault=%b", g, fi[g], ff[g]);
        end else begin
          mon_e = q.pop_front();
          if (mon_e.d != g || fi[g] !== mon_e.i || ff[g] !== mon_e.f) begin
            failures++;
            $display("FAIL fetch dut=%0d instr=%h fault=%b, want dut=%0d instr=%h fault=%b",
                     g, fi[g], ff[g], mon_e.d, mon_e.i, mon_e.f);
          end
        end
      end
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", n, act, exp);
    end
  endtask
  task automatic fetch(int d, logic [31:0] a, logic [31:0] ei, logic [1:0] ef);
    q.push_back('{d, ei, ef});
    fr[d] = 1;
    fa[d] = a;
    @(posedge clk); #1;
    fr[d] = 0;
  endtask
  task automatic pulse_start(int d);
    ls[d] = 1;
    @(posedge clk); #1;
    ls[d] = 0;
    chk("loading_after_start", 32'(lg[d]), 32'd1);
  endtask
  task automatic send_img(int d);
    foreach (img[i]) begin
      bv[d] = 1;
      lb[d] = img[i];
      lst[d] = (i == img.size() - 1);
      @(posedge clk); #1;
    end
    bv[d] = 0;
    lst[d] = 0;
    chk("load_done_pulse", 32'(ld[d]), 32'd1);
    chk("loading_cleared", 32'(lg[d]), 32'd0);
    @(posedge clk); #1;
    chk("load_done_single", 32'(ld[d]), 32'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    for (int i = 0; i < 3; i++) begin
      ls[i] = 0; bv[i] = 0; lst[i] = 0; fr[i] = 0; lb[i] = 0; fa[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    // reset state and empty array
    chk("rst_loading", 32'(lg[0]), 32'd0);
    chk("rst_overflow", 32'(lo[0]), 32'd0);
    chk("rst_fetch_ready", 32'(frdy[0]), 32'd1);
    fetch(0, 32'd0, 32'd0, FAULT_OK);
    // program load, big-endian
    img = '{8'h20, 8'h00, 8'h00, 8'h03, 8'h20, 8'h21, 8'h00, 8'h04};
    pulse_start(0);
    send_img(0);
    fetch(0, 32'd0, mk_itype(OP_ADDI, 5'd0, 5'd0, 16'd3), FAULT_OK);
    fetch(0, 32'd4, 32'h2021_0004, FAULT_OK);
    fetch(0, 32'd8, 32'd0, FAULT_OK);
    // faults
    fetch(0, 32'd6, 32'd0, FAULT_MISALIGN);
    fetch(0, 32'd256, 32'd0, FAULT_RANGE);
    fetch(0, 32'h0000_0102, 32'd0, FAULT_MISALIGN);
    fetch(0, 32'hFFFF_FFFC, 32'd0, FAULT_RANGE);
    fetch(0, 32'd252, 32'd0, FAULT_OK);
    // overflow on a 2-word array
    img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
    pulse_start(1);
    send_img(1);
    chk("overflow_set", 32'(lo[1]), 32'd1);
    fetch(1, 32'd0, 32'h0102_0304, FAULT_OK);
    fetch(1, 32'd4, 32'h0506_0708, FAULT_OK);
    fetch(1, 32'd8, 32'd0, FAULT_RANGE);
    img = '{8'h11};
    pulse_start(1);
    chk("overflow_cleared", 32'(lo[1]), 32'd0);
    send_img(1);
    chk("overflow_stays_clear", 32'(lo[1]), 32'd0);
    fetch(1, 32'd0, 32'h1100_0000, FAULT_OK);
    fetch(1, 32'd4, 32'h0506_0708, FAULT_OK);
    // zero-padded partial word, both byte orders
    img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    pulse_start(0);
    send_img(0);
    fetch(0, 32'd0, 32'hAABB_CCDD, FAULT_OK);
    fetch(0, 32'd4, 32'hEE00_0000, FAULT_OK);
    pulse_start(2);
    send_img(2);
    fetch(2, 32'd0, 32'hDDCC_BBAA, FAULT_OK);
    fetch(2, 32'd4, 32'h0000_00EE, FAULT_OK);
    // fetch blocked during a long load, then reset mid-load
    pulse_start(0);
    for (int i = 0; i < 6; i++) begin
      bv[0] = 1;
      lb[0] = 8'(8'h30 + i);
      fr[0] = (i == 4);
      fa[0] = 32'd0;
      if (i == 4) chk("fetch_ready_in_load", 32'(frdy[0]), 32'd0);
      @(posedge clk); #1;
    end
    bv[0] = 0;
    fr[0] = 0;
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    chk("midrst_loading", 32'(lg[0]), 32'd0);
    chk("midrst_overflow", 32'(lo[0]), 32'd0);
    chk("midrst_done", 32'(ld[0]), 32'd0);
    chk("midrst_fetch", {fv[0], ff[0], fi[0][28:0]}, 32'd0);
    chk("midrst_instr", fi[0], 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    fetch(0, 32'd0, 32'd0, FAULT_OK);
    fetch(0, 32'd4, 32'd0, FAULT_OK);
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
